// File: rtl/avln_st_pkt_fifo.sv
// Avalon-ST FIFO with optional store-and-forward packet mode, packet/fill
// accounting and ingress framing-error detection.
module avln_st_pkt_fifo #(
    parameter int W        = 32,
    parameter int B        = 8,
    parameter int DEPTH    = 16,
    parameter int PKT_MODE = 0,
    localparam int BPW     = W / B,
    localparam int EW      = (BPW > 1) ? $clog2(BPW) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic [EW-1:0] in_empty,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [EW-1:0] out_empty,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fill_level,
    output logic [AW:0]   pkt_count,
    output logic          framing_err
);

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [W-1:0]  data;
    } beat_t;

    beat_t       mem [DEPTH];
    beat_t       head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        is_full;
    logic        is_empty;
    logic        push;
    logic        pop;
    logic        draining;
    logic        in_pkt;

    // The extra pointer MSB separates the full and empty cases at equal indices.
    assign is_empty   = (wr_ptr == rd_ptr);
    assign is_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill_level = wr_ptr - rd_ptr;

    assign in_ready = !is_full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = head.data;
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;
    assign out_empty = head.empty;

    // Store-and-forward holds the head back until a whole packet is stored,
    // unless a packet is already leaving or the buffer is full (oversize escape).
    always_comb begin
        out_valid = !is_empty;
        if (PKT_MODE != 0) begin
            out_valid = !is_empty && ((pkt_count != '0) || draining || is_full);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_sop, in_eop, in_empty, in_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pkt_count   <= '0;
            draining    <= 1'b0;
            in_pkt      <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + (AW+1)'(1);
                draining <= !head.eop;
            end
            case ({push && in_eop, pop && head.eop})
                2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
                2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
                default: pkt_count <= pkt_count;
            endcase
            // Offending beats are still stored; the tracker simply follows them.
            framing_err <= push && ((in_sop && in_pkt) || (!in_sop && !in_pkt));
            if (push) begin
                if (in_eop) begin
                    in_pkt <= 1'b0;
                end else if (in_sop) begin
                    in_pkt <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avln_st_pkt_fifo.sv
// Scoreboard bench for avln_st_pkt_fifo: three instances (cut-through/16,
// store-and-forward/16, store-and-forward/8) checked against a queue model.
module tb_avln_st_pkt_fifo;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] in_data   [N];
    logic        in_sop    [N];
    logic        in_eop    [N];
    logic [1:0]  in_empty  [N];
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [31:0] out_data  [N];
    logic        out_sop   [N];
    logic        out_eop   [N];
    logic [1:0]  out_empty [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] fill      [N];
    logic [31:0] pkts      [N];
    logic        ferr      [N];

    for (genvar g = 0; g < N; g++) begin : u
        localparam int D  = (g == 2) ? 8 : 16;
        localparam int PM = (g == 0) ? 0 : 1;
        logic [$clog2(D):0] fl;
        logic [$clog2(D):0] pc;

        avln_st_pkt_fifo #(.W(32), .B(8), .DEPTH(D), .PKT_MODE(PM)) dut (
            .clk        (clk),
            .reset      (reset),
            .in_data    (in_data[g]),
            .in_sop     (in_sop[g]),
            .in_eop     (in_eop[g]),
            .in_empty   (in_empty[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .out_data   (out_data[g]),
            .out_sop    (out_sop[g]),
            .out_eop    (out_eop[g]),
            .out_empty  (out_empty[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .fill_level (fl),
            .pkt_count  (pc),
            .framing_err(ferr[g])
        );

        assign fill[g] = 32'(fl);
        assign pkts[g] = 32'(pc);
    end

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    // Reference model: the stored beats as a plain queue per instance.
    beat_t mq     [N][$];
    bit    mdrn   [N];
    bit    minpkt [N];
    bit    mferr  [N];
    bit    acc    [N];

    int checks = 0;
    int errors = 0;
    bit timeout_hit  = 1'b0;
    bit timeout_seen = 1'b0;

    task automatic checkOutput(string name, int g, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // Monitor: compare every instance each cycle, then advance the model with
    // the handshakes the model itself grants.
    always @(negedge clk) begin : chk
        int    d;
        int    sz;
        int    np;
        bit    ev;
        bit    pu;
        bit    po;
        beat_t hb;
        for (int g = 0; g < N; g++) begin
            d = (g == 2) ? 8 : 16;
            if (reset) begin
                mq[g].delete();
                mdrn[g]   = 1'b0;
                minpkt[g] = 1'b0;
                mferr[g]  = 1'b0;
                acc[g]    = 1'b0;
                checkOutput("rst_out_valid", g, 32'(out_valid[g]), 0);
                checkOutput("rst_in_ready", g, 32'(in_ready[g]), 0);
                checkOutput("rst_fill_level", g, fill[g], 0);
                checkOutput("rst_pkt_count", g, pkts[g], 0);
                checkOutput("rst_framing_err", g, 32'(ferr[g]), 0);
            end else begin
                sz = mq[g].size();
                np = 0;
                for (int i = 0; i < sz; i++) begin
                    if (mq[g][i].eop) np++;
                end
                ev = (sz > 0) && ((g == 0) || (np > 0) || mdrn[g] || (sz == d));
                checkOutput("in_ready", g, 32'(in_ready[g]), 32'(sz < d));
                checkOutput("out_valid", g, 32'(out_valid[g]), 32'(ev));
                checkOutput("fill_level", g, fill[g], 32'(sz));
                checkOutput("pkt_count", g, pkts[g], 32'(np));
                checkOutput("framing_err", g, 32'(ferr[g]), 32'(mferr[g]));
                if (ev && out_valid[g]) begin
                    hb = mq[g][0];
                    checkOutput("out_data", g, out_data[g], hb.data);
                    checkOutput("out_sop", g, 32'(out_sop[g]), 32'(hb.sop));
                    checkOutput("out_eop", g, 32'(out_eop[g]), 32'(hb.eop));
                    checkOutput("out_empty", g, 32'(out_empty[g]), 32'(hb.empty));
                end
                pu = in_valid[g] && (sz < d);
                po = ev && out_ready[g];
                mferr[g] = pu && ((in_sop[g] && minpkt[g]) || (!in_sop[g] && !minpkt[g]));
                if (po) begin
                    hb = mq[g].pop_front();
                    mdrn[g] = !hb.eop;
                end
                if (pu) begin
                    mq[g].push_back({in_data[g], in_sop[g], in_eop[g], in_empty[g]});
                    if (in_eop[g]) minpkt[g] = 1'b0;
                    else if (in_sop[g]) minpkt[g] = 1'b1;
                end
                acc[g] = pu;
            end
        end
        if (timeout_hit && !timeout_seen) begin
            timeout_seen = 1'b1;
            checkOutput("accept_timeout", 0, 32'(timeout_hit), 0);
        end
    end

    // Drive one beat and hold it until accepted (bounded); leaves valid low.
    task automatic applyStimulus(int g, logic [31:0] d, logic s, logic e, logic [1:0] em);
        int t = 0;
        in_data[g]  = d;
        in_sop[g]   = s;
        in_eop[g]   = e;
        in_empty[g] = em;
        in_valid[g] = 1'b1;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!acc[g] && t < 100);
        if (!acc[g]) timeout_hit = 1'b1;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic randomBeat(int g);
        in_data[g]  = $urandom;
        in_sop[g]   = 1'($urandom_range(0, 1));
        in_eop[g]   = 1'($urandom_range(0, 1));
        in_empty[g] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            in_data[g]   = '0;
            in_sop[g]    = 1'b0;
            in_eop[g]    = 1'b0;
            in_empty[g]  = '0;
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
        end
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] single-beat packet, cut-through");
        out_ready[0] = 1'b1;
        applyStimulus(0, 32'hA5A5A5A5, 1'b1, 1'b1, 2'd2);
        idle(3);

        $display("[TB] fill to full then stream across pointer wraps");
        out_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, $urandom, 1'(i == 0), 1'(i == 15), 2'($urandom_range(0, 3)));
        end
        randomBeat(0);
        in_valid[0] = 1'b1;
        idle(3);
        out_ready[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            randomBeat(0);
            idle(1);
        end
        in_valid[0] = 1'b0;
        idle(20);

        $display("[TB] store-and-forward 5-beat packet with stall before eop");
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, $urandom, 1'(i == 0), 1'b0, 2'd0);
        end
        idle(3);
        applyStimulus(1, $urandom, 1'b0, 1'b1, 2'd1);
        idle(8);

        $display("[TB] store-and-forward 20-beat packet through depth 8");
        out_ready[2] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(2, $urandom, 1'(i == 0), 1'(i == 19), 2'd0);
        end
        idle(12);

        $display("[TB] framing violations");
        applyStimulus(0, 32'h0000_0001, 1'b1, 1'b0, 2'd0);
        applyStimulus(0, 32'h0000_0002, 1'b0, 1'b0, 2'd0);
        applyStimulus(0, 32'h0000_0003, 1'b1, 1'b0, 2'd0);
        applyStimulus(0, 32'h0000_0004, 1'b0, 1'b1, 2'd3);
        applyStimulus(0, 32'h0000_0005, 1'b0, 1'b1, 2'd1);
        idle(5);

        $display("[TB] reset mid-packet");
        out_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, $urandom, 1'(i == 0), 1'b0, 2'd0);
        end
        #2 reset = 1'b1;
        idle(2);
        reset = 1'b0;
        out_ready[0] = 1'b1;
        applyStimulus(0, 32'h1234_5678, 1'b1, 1'b1, 2'd0);
        idle(4);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < N; g++) begin
                randomBeat(g);
                in_valid[g]  = 1'($urandom_range(0, 1));
                out_ready[g] = ($urandom_range(0, 3) != 0);
            end
            idle(1);
        end
        for (int g = 0; g < N; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
        end
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avln_st_pkt_fifo.md
Name: avln_st_pkt_fifo

Overview:
- Parametrised Avalon-ST FIFO carrying the standard stream beat: data, sop, eop, empty, valid/ready.
- Data width, symbol width and depth are configurable.
- Adds a store-and-forward packet mode that releases a packet only once its eop beat is stored. Includes a full-buffer escape, so oversized packets cannot deadlock.
- Placed between stream producers and consumers in the datapath. It provides elastic buffering, rate decoupling and framing-error detection.

Parameters:
- W, 32, data word width in bits; must be a multiple of B.
- B, 8, symbol width in bits; BpW = W/B; empty field width EW = max(1, $clog2(BpW)).
- DEPTH, 16, storage entries; power of 2, >= 2.
- PKT_MODE, 0, 0 = cut-through streaming, 1 = store-and-forward.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  W  ingress beat data.
- in_sop  in  1  ingress start of packet.
- in_eop  in  1  ingress end of packet.
- in_empty  in  EW  unused symbols on eop beat; stored verbatim on every beat.
- in_valid  in  1  ingress beat valid.
- in_ready  out  1  FIFO can accept a beat.
- out_data  out  W  egress beat data.
- out_sop  out  1  egress start of packet.
- out_eop  out  1  egress end of packet.
- out_empty  out  EW  egress empty field.
- out_valid  out  1  egress beat valid.
- out_ready  in  1  downstream accepts beat.
- fill_level  out  $clog2(DEPTH)+1  stored beat count, 0..DEPTH.
- pkt_count  out  $clog2(DEPTH)+1  stored complete packets (eop beats in storage).
- framing_err  out  1  one-cycle pulse on ingress framing violation.

Behaviour:
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage is a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit.
  - full = pointers differ only in MSB.
  - empty = pointers equal.
- in_ready = !full. No combinational path from out_ready to in_ready.
  - When full and popping in the same cycle, in_ready stays 0 that cycle.
- Egress is first-word-fall-through from the head entry. Latency: a beat pushed at edge t can appear on out_* with out_valid in the cycle after edge t; no same-cycle bypass.
- out_* data fields hold the head entry whenever out_valid=1. They are don't-care when out_valid=0.
- Simultaneous push and pop at non-full, non-empty level: both complete, fill_level unchanged.
- Pointer wrap: index bits roll DEPTH-1 -> 0 and the MSB toggles. There is no limit on wrap count.
- pkt_count:
  - +1 on push of an eop beat; -1 on pop of an eop beat; unchanged when both occur.
  - Never exceeds fill_level.
- Cut-through mode (PKT_MODE=0): out_valid = !empty.
- Store-and-forward mode (PKT_MODE=1): out_valid = !empty & (pkt_count != 0 | draining | full).
  - draining register: set on pop of a non-eop beat, cleared on pop of an eop beat. Once a packet's first beat leaves, the rest follows as it arrives.
  - Full escape: when full with pkt_count=0, the head is released and draining engages. This is required for packets longer than DEPTH.
- Framing tracker: in_pkt register, set on push with sop & !eop, cleared on push with eop.
  - framing_err pulses, registered, in the cycle after a push where either:
    - (in_sop & in_pkt), a missing eop; or
    - (!in_sop & !in_pkt), a beat outside any packet.
  - Offending beats are still stored unmodified. After an error, in_pkt follows the offending beat's sop/eop.
- Beats with in_valid=0 are ignored regardless of the other in_* fields.
- Reset (asynchronous, any cycle, including mid-packet) clears:
  - pointers, fill_level=0, pkt_count=0, draining=0, in_pkt=0, framing_err=0, out_valid=0;
  - in_ready=0 while reset is high, 1 in the first cycle after release.
  - Storage contents are not reset. Partial packets are discarded.

Test Plan:
- Cut-through, DEPTH=16: push 1-beat packet (sop=eop=1, data 0xA5A5A5A5, empty=2) at edge t -> out_valid=1 in the cycle after t with identical fields; fill_level 1 -> 0 after pop.
- Fill 16 beats with out_ready=0 -> in_ready=0, fill_level=16. Then hold in_valid=1 and out_ready=1 for 40 cycles -> every beat in order, no loss/duplication across 2+ pointer wraps, in_ready never 1 while full.
- PKT_MODE=1: push 5-beat packet, stall 3 cycles before eop -> out_valid=0 until the cycle after the eop push; pkt_count=1; all 5 beats then drain back-to-back.
- PKT_MODE=1, DEPTH=8: 20-beat packet with out_ready=1 -> out_valid rises when fill_level=8 (pkt_count=0); all 20 beats delivered in order; draining clears after eop pop.
- Framing: sop, beat, sop (no eop), eop -> single framing_err pulse the cycle after the second sop push; then a beat with sop=0 after eop -> another pulse; all 5 beats output unmodified.
- Assert reset mid-packet with fill_level=6 -> asynchronously out_valid=0, fill_level=0, pkt_count=0, in_ready=0. After release, a new 1-beat packet passes with 1-cycle latency and no stale data.
